// File: rtl/prach_buffer_cp_unpack.sv
// PRACH CP buffer read-side unpacker: pops packed words from the FIFO,
// serializes one sample per cycle, strips the cyclic prefix.
module prach_buffer_cp_unpack #(
    parameter int WIDTH = 144,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_cp_len,
    input  logic [CNT_W-1:0]         cfg_seq_len,
    output logic                     busy,
    output logic                     done,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH/LANES-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int SW = WIDTH / LANES;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CP,
        S_SEQ
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_vld_q, word_vld_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [CNT_W-1:0] cp_cnt_q, cp_cnt_d;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0] cp_len_q, cp_len_d;
    logic [CNT_W-1:0] seq_len_q, seq_len_d;
    logic             done_q, done_d;

    logic consume;
    logic lane_end;
    logic seq_final;
    logic load;

    // A held lane is used up: discarded in CP, handed off in SEQ
    always_comb begin
        consume = 1'b0;
        if (word_vld_q) begin
            if (state_q == S_CP) begin
                consume = 1'b1;
            end else if (state_q == S_SEQ) begin
                consume = out_ready;
            end
        end
    end

    assign lane_end  = (lane_q == LW'(LANES - 1));
    assign seq_final = (state_q == S_SEQ) &&
                       (seq_cnt_q == seq_len_q - CNT_W'(1));

    // Refill when empty, or on the wrap of the last lane unless the
    // occasion ends on it (keeps the next occasion word-aligned)
    assign in_ready = (state_q != S_IDLE) &&
                      (!word_vld_q ||
                       (consume && lane_end && !seq_final));
    assign load     = in_valid && in_ready;

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_valid = (state_q == S_SEQ) && word_vld_q;
    assign out_last  = seq_final;

    // Present the lane selected by the lane pointer
    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
                out_data = word_q[i*SW +: SW];
            end
        end
    end

    // Next-state: occasion control, lane walk, counters, refill
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        word_vld_d = word_vld_q;
        lane_d     = lane_q;
        cp_cnt_d   = cp_cnt_q;
        seq_cnt_d  = seq_cnt_q;
        cp_len_d   = cp_len_q;
        seq_len_d  = seq_len_q;
        done_d     = 1'b0;

        if (state_q == S_IDLE) begin
            if (start && (cfg_seq_len != '0)) begin
                cp_len_d   = cfg_cp_len;
                seq_len_d  = cfg_seq_len;
                cp_cnt_d   = '0;
                seq_cnt_d  = '0;
                lane_d     = '0;
                word_vld_d = 1'b0;
                state_d    = (cfg_cp_len != '0) ? S_CP : S_SEQ;
            end
        end else begin
            if (consume) begin
                if (lane_end) begin
                    lane_d     = '0;
                    word_vld_d = 1'b0;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end

            if (load) begin
                word_d     = in_data;
                word_vld_d = 1'b1;
                lane_d     = '0;
            end

            if (consume && (state_q == S_CP)) begin
                cp_cnt_d = cp_cnt_q + CNT_W'(1);
                if (cp_cnt_q == cp_len_q - CNT_W'(1)) begin
                    state_d = S_SEQ;
                end
            end

            if (consume && (state_q == S_SEQ)) begin
                seq_cnt_d = seq_cnt_q + CNT_W'(1);
                if (seq_final) begin
                    word_vld_d = 1'b0;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            lane_q     <= '0;
            cp_cnt_q   <= '0;
            seq_cnt_q  <= '0;
            cp_len_q   <= '0;
            seq_len_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            lane_q     <= lane_d;
            cp_cnt_q   <= cp_cnt_d;
            seq_cnt_q  <= seq_cnt_d;
            cp_len_q   <= cp_len_d;
            seq_len_q  <= seq_len_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_prach_buffer_cp_unpack.sv
// Bench for prach_buffer_cp_unpack: FIFO model, sample-stream model,
// per-cycle compare plus literal pins per directed occasion.
module tb_prach_buffer_cp_unpack;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [15:0]   cfg_cp_len;
    logic [15:0]   cfg_seq_len;
    logic          busy;
    logic          done;
    logic [143:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [35:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    always #5 clk = ~clk;

    prach_buffer_cp_unpack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_cp_len  (cfg_cp_len),
        .cfg_seq_len (cfg_seq_len),
        .busy        (busy),
        .done        (done),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // show-ahead FIFO model
    logic [143:0] fmem [0:63];
    int           fwr;
    int           frd;
    logic         gate;
    logic         pend_pop;

    assign in_valid = (frd != fwr) && !gate;
    assign in_data  = fmem[frd % 64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) frd <= 0;
        else if (pend_pop) frd <= frd + 1;
    end

    function automatic logic [35:0] samp(input int n);
        return {18'(n * 3 + 1), 18'(n)};
    endfunction

    function automatic logic [35:0] samp_at(input int s);
        logic [143:0] w;
        w = fmem[(s / 4) % 64];
        return w[(s % 4) * 36 +: 36];
    endfunction

    function automatic void chk(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // stream model: sample pointer, current occasion window
    bit          m_busy;
    bit          m_done;
    int          msp;
    int          m_base;
    int          m_len;
    int          m_k;
    int          m_words;
    bit          stall_q;
    logic [35:0] stall_d;
    logic        stall_l;
    int          cyc = 0;
    int          n_out = 0;
    int          done_cnt = 0;
    logic [35:0] log_d [0:1023];
    logic        log_l [0:1023];
    int          log_c [0:1023];

    always @(negedge clk) begin
        bit was_busy;
        if (!rst_n) begin
            m_busy   = 0;
            m_done   = 0;
            msp      = 0;
            m_base   = 0;
            m_len    = 0;
            m_k      = 0;
            m_words  = 0;
            stall_q  = 0;
            pend_pop = 0;
        end else begin
            cyc++;
            was_busy = m_busy;
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("done", {63'd0, done}, {63'd0, m_done});
            if (done) done_cnt++;
            if (!m_busy) begin
                chk("in_ready_idle", {63'd0, in_ready}, 64'd0);
                chk("out_valid_idle", {63'd0, out_valid}, 64'd0);
            end
            if (m_done) chk("pops_total", 64'(frd), 64'(m_words));
            m_done = 0;
            if (stall_q) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", {28'd0, out_data}, {28'd0, stall_d});
                chk("stall_last", {63'd0, out_last}, {63'd0, stall_l});
            end
            stall_q = 0;
            if (m_busy && out_valid) begin
                chk("out_data", {28'd0, out_data},
                    {28'd0, samp_at(m_base + m_k)});
                chk("out_last", {63'd0, out_last},
                    {63'd0, (m_k == m_len - 1)});
                if (out_ready) begin
                    log_d[n_out % 1024] = out_data;
                    log_l[n_out % 1024] = out_last;
                    log_c[n_out % 1024] = cyc;
                    n_out++;
                    m_k++;
                    if (m_k == m_len) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end else begin
                    stall_q = 1;
                    stall_d = out_data;
                    stall_l = out_last;
                end
            end
            if (!was_busy && start && cfg_seq_len != 0) begin
                m_busy  = 1;
                m_base  = msp + int'(cfg_cp_len);
                m_len   = int'(cfg_seq_len);
                m_k     = 0;
                msp     = ((msp + int'(cfg_cp_len) + int'(cfg_seq_len)
                            + 3) / 4) * 4;
                m_words = msp / 4;
            end
            pend_pop = in_valid && in_ready;
        end
    end

    task automatic push(input int base);
        fmem[fwr % 64] = {samp(base + 3), samp(base + 2),
                          samp(base + 1), samp(base)};
        fwr++;
    endtask

    task automatic run(input int cp, input int seq, input bit tog,
                       input int gap_at, input int stop_n,
                       input int restart_at);
        int d0;
        int o0;
        int c;
        d0 = done_cnt;
        o0 = n_out;
        c  = 0;
        @(posedge clk); #2;
        start       = 1;
        cfg_cp_len  = 16'(cp);
        cfg_seq_len = 16'(seq);
        @(posedge clk); #2;
        start = 0;
        while (done_cnt == d0 && (n_out - o0) < stop_n && c < 300) begin
            c++;
            if (tog) out_ready = ~out_ready;
            gate = (gap_at > 0 && c >= gap_at && c < gap_at + 3);
            if (c == restart_at) begin
                start       = 1;
                cfg_cp_len  = 16'd1;
                cfg_seq_len = 16'd2;
            end else begin
                start = 0;
            end
            @(posedge clk); #2;
        end
        if (c >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: got no done expected done");
        end
        out_ready = 1;
        gate      = 0;
        start     = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        int f0;
        rst_n       = 0;
        start       = 0;
        cfg_cp_len  = 0;
        cfg_seq_len = 0;
        out_ready   = 1;
        gate        = 0;
        fwr         = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_out_data", {28'd0, out_data}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1;

        // aligned occasion
        for (int w = 0; w < 6; w++) push(w * 4);
        o0 = n_out;
        f0 = frd;
        run(8, 16, 0, 0, 1000, 0);
        chk("t1_pops", 64'(frd - f0), 64'd6);
        chk("t1_count", 64'(n_out - o0), 64'd16);
        chk("t1_first", {28'd0, log_d[o0]}, {28'd0, 18'd25, 18'd8});
        chk("t1_last", {28'd0, log_d[o0 + 15]}, {28'd0, 18'd70, 18'd23});
        chk("t1_last_flag", {63'd0, log_l[o0 + 15]}, 64'd1);
        chk("t1_span", 64'(log_c[o0 + 15] - log_c[o0]), 64'd15);

        // unaligned straddle then cp_len 0 follow-up
        for (int w = 0; w < 4; w++) push(w * 4);
        o0 = n_out;
        f0 = frd;
        run(5, 6, 0, 0, 1000, 0);
        chk("t2_pops", 64'(frd - f0), 64'd3);
        chk("t2_first", {28'd0, log_d[o0]}, {28'd0, 18'd16, 18'd5});
        chk("t2_last", {28'd0, log_d[o0 + 5]}, {28'd0, 18'd31, 18'd10});
        o0 = n_out;
        f0 = frd;
        run(0, 4, 0, 0, 1000, 0);
        chk("t2b_pops", 64'(frd - f0), 64'd1);
        chk("t2b_first", {28'd0, log_d[o0]}, {28'd0, 18'd37, 18'd12});

        // single sample
        push(40);
        o0 = n_out;
        f0 = frd;
        run(0, 1, 0, 0, 1000, 0);
        chk("t3_pops", 64'(frd - f0), 64'd1);
        chk("t3_data", {28'd0, log_d[o0]}, {28'd0, 18'd121, 18'd40});
        chk("t3_last", {63'd0, log_l[o0]}, 64'd1);

        // backpressure with FIFO-empty gap
        for (int w = 0; w < 4; w++) push(50 + w * 4);
        o0 = n_out;
        f0 = frd;
        run(3, 12, 1, 4, 1000, 0);
        chk("t4_pops", 64'(frd - f0), 64'd4);
        chk("t4_count", 64'(n_out - o0), 64'd12);
        chk("t4_last", {28'd0, log_d[o0 + 11]}, {28'd0, 18'd193, 18'd64});

        // ignored starts
        push(70);
        f0 = frd;
        @(posedge clk); #2;
        start       = 1;
        cfg_cp_len  = 16'd3;
        cfg_seq_len = 16'd0;
        @(posedge clk); #2;
        start = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("t5_no_pop", 64'(frd - f0), 64'd0);
        chk("t5_idle", {63'd0, busy}, 64'd0);
        push(74);
        o0 = n_out;
        run(2, 6, 0, 0, 1000, 5);
        chk("t5_count", 64'(n_out - o0), 64'd6);
        chk("t5_first", {28'd0, log_d[o0]}, {28'd0, 18'd217, 18'd72});

        // reset in the middle of SEQ
        for (int w = 0; w < 4; w++) push(200 + w * 4);
        run(0, 12, 0, 0, 3, 0);
        rst_n = 0;
        #1;
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_out_data", {28'd0, out_data}, 64'd0);
        chk("t6_in_ready", {63'd0, in_ready}, 64'd0);
        chk("t6_out_last", {63'd0, out_last}, 64'd0);
        fwr = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        push(300);
        push(304);
        o0 = n_out;
        run(1, 6, 0, 0, 1000, 0);
        chk("t6_first", {28'd0, log_d[o0]}, {28'd0, 18'd904, 18'd301});
        chk("t6_last", {28'd0, log_d[o0 + 5]}, {28'd0, 18'd919, 18'd306});
        chk("t6_pops", 64'(frd), 64'd2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prach_buffer_cp_unpack.md
# prach_buffer_cp_unpack

Read-side consumer of the PRACH CP buffer FIFO. It pops 144-bit words (4 packed time samples), serializes them into one 36-bit complex sample per cycle, and removes the cyclic prefix. It discards the first `cfg_cp_len` samples of an occasion and forwards the next `cfg_seq_len` samples downstream with a last marker. It sits in the read clock domain, directly on the FIFO's show-ahead read port.

## Interface

Parameters:
- `WIDTH`, 144, input word width.
- `LANES`, 4, samples per word; `SW = WIDTH/LANES` = 36 (I in [17:0], Q in [35:18]).
- `CNT_W`, 16, width of the length config and counters.

Ports:
- `clk`  in  1  single clock; the FIFO read clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches the config and begins an occasion.
- `cfg_cp_len`  in  CNT_W  samples to discard, 0 allowed.
- `cfg_seq_len`  in  CNT_W  samples to forward, must be ≥1.
- `busy`  out  1  occasion in progress.
- `done`  out  1  one-cycle pulse after the last forwarded sample.
- `in_data`  in  WIDTH  FIFO show-ahead head word; lane 0 in [SW-1:0] is the earliest sample.
- `in_valid`  in  1  FIFO non-empty.
- `in_ready`  out  1  pop request; a word is consumed when `in_valid && in_ready`.
- `out_data`  out  SW  sample.
- `out_valid`  out  1  sample valid.
- `out_ready`  in  1  downstream accept.
- `out_last`  out  1  marks sample number `cfg_seq_len` of the occasion.

## Operation

- States: IDLE, CP, SEQ.
- IDLE:
  - `start` with `cfg_seq_len != 0`: latch both lengths, clear counters and the lane pointer.
  - Next state is CP if `cfg_cp_len != 0`, else SEQ.
  - `start` with `cfg_seq_len == 0` is ignored.
  - `start` while `busy` is ignored.
- Holding register: one word plus `word_vld` plus lane pointer `lane` (0..LANES-1).
- `in_ready` = (state is CP or SEQ) && (!`word_vld` || (current lane consumed this cycle && `lane == LANES-1` && the consumed lane is not the occasion's final sample)).
  - This gives one sample per cycle with no refill bubble.
  - `in_ready` is never asserted in IDLE, so no spurious FIFO pops occur.
- A lane is consumed when `word_vld` holds and:
  - in CP: unconditionally (discard, no output);
  - in SEQ: on `out_valid && out_ready`.
- `lane` increments on each consumed lane and wraps LANES-1 → 0, clearing `word_vld` unless a new word is loaded in the same cycle.
- CP counter: counts discarded samples; on the `cfg_cp_len`-th, go to SEQ.
  - The lane pointer carries over, so a word straddling the CP/SEQ boundary continues in SEQ with its next lane.
- SEQ counter: counts forwarded samples. `out_last` = SEQ && counter == `cfg_seq_len-1`.
- On the last handshake:
  - clear `word_vld`, discarding any residual lanes of that word;
  - go to IDLE and pulse `done`.
  - The next occasion always starts word-aligned.
- `out_data` = lane `lane` of the held word. `out_valid` = SEQ && `word_vld`.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.
- Counters are CNT_W bits, compare-to-length only; no wrap inside an occasion.

## Timing

- Reset values: `busy`=0, `done`=0, `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, state IDLE, `word_vld`=0, `lane`=0, counters 0.
- Reset mid-occasion: everything returns to reset values immediately. The held word is dropped, and the upstream FIFO is reset by the same `rst_n`.
- `start` at cycle t: `busy`=1 and `in_ready`=`!word_vld`=1 from t+1.
- Word accepted at cycle n: its lane 0 is consumed or presented at n+1.
- Steady state: one sample per cycle while `in_valid` and `out_ready` are held high.
- `done` asserts the cycle after the last handshake, with `busy`=0 in that same cycle. A `start` in the `done` cycle is accepted.
- `in_ready` is combinational from `out_ready` in SEQ only on the lane-wrap path. `out_valid` does not depend on `out_ready`.
- FIFO empty (`in_valid`=0) while a word is needed: stall with no counter advance and `out_valid`=0 once the held word is exhausted.

## Test plan

- **Aligned occasion.** cp_len=8, seq_len=16; FIFO preloaded with 6 words of sample index 0..23; `out_ready`=1.
  - Exactly 6 pops.
  - Outputs 8..23 on 16 consecutive cycles, `out_last` on 23.
  - `done` the next cycle.
- **Unaligned straddle.** cp_len=5, seq_len=6; words 0..15.
  - Outputs 5..10, `out_last` on 10.
  - 3 pops: lane 3 of word 2 (sample 11) is discarded.
  - A next occasion with cp_len=0, seq_len=4 outputs 12..15.
- **cp_len=0.** seq_len=1: outputs sample 0 with `out_last`=1, one pop, `done`.
- **Backpressure and empty FIFO.** seq_len=12 with `out_ready` toggling 1/0 every cycle and a 3-cycle FIFO-empty gap.
  - Output sequence is identical to the unstalled run.
  - `out_data` is stable during stalls.
  - No pops while `in_valid`=0.
- **Ignored starts.** `start` with seq_len=0 leaves `busy`=0 and no pops; `start` during SEQ does not change the lengths or counters.
- **Reset mid-SEQ.** Deassert `rst_n` after 3 output samples.
  - All outputs are 0 asynchronously.
  - After release plus `start`, output resumes from the freshly reset FIFO contents, word-aligned.
